// File: rtl/pmem_responder_pkg.sv
// Shared types for the physical-memory responder: bus word/block types,
// responder FSM state and latency counter width.
package pmem_responder_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_block;
    typedef logic [3:0]   lc3b_pmem_lat;

    typedef enum logic [1:0] {
        PMEM_IDLE,
        PMEM_BUSY,
        PMEM_RESP
    } lc3b_pmem_state;

endpackage

// File: rtl/pmem_store.sv
// Block store behind the responder: 2^LINE_BITS x 128-bit entries,
// synchronous write, asynchronous read. Contents are deliberately not reset.
module pmem_store
    import pmem_responder_pkg::*;
#(
    parameter int LINE_BITS = 5
) (
    input  logic                 clk,
    input  logic                 write,
    input  logic [LINE_BITS-1:0] index,
    input  lc3b_block            datain,
    output lc3b_block            dataout
);

    lc3b_block data_q [2**LINE_BITS];

    always_ff @(posedge clk) begin
        if (write) begin
            data_q[index] <= datain;
        end
    end

    assign dataout = data_q[index];

endmodule

// File: rtl/pmem_responder.sv
// Physical-memory responder for the 128-bit block bus: fixed-latency
// read/write service with a sticky flag for initiator protocol violations.
//
// state     | meaning
// PMEM_IDLE | waiting for pmem_read/pmem_write; latches the request
// PMEM_BUSY | counting down latency; access commits when counter hits 0
// PMEM_RESP | pmem_resp high for this one cycle; request ignored
module pmem_responder
    import pmem_responder_pkg::*;
#(
    parameter int LATENCY   = 4,
    parameter int LINE_BITS = 5
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      pmem_read,
    input  logic      pmem_write,
    input  lc3b_word  pmem_address,
    input  lc3b_block pmem_wdata,
    output lc3b_block pmem_rdata,
    output logic      pmem_resp,
    output logic      pmem_error
);

    localparam lc3b_pmem_lat LAT_LOAD = (LATENCY > 1) ? lc3b_pmem_lat'(LATENCY - 2) : '0;

    lc3b_pmem_state       state_q;
    lc3b_pmem_lat         cnt_q;
    logic                 rd_q, wr_q;
    logic [11:0]          addr_q;
    lc3b_block            wdata_q;
    lc3b_block            rdata_q;
    logic                 resp_q;
    logic                 error_q;

    logic                 accept, commit_now, commit_wr, store_we, viol;
    logic [LINE_BITS-1:0] store_index;
    lc3b_block            store_wdata, store_rdata;
    logic                 unused_addr_lsb;

    assign unused_addr_lsb = ^pmem_address[3:0];

    assign accept = (state_q == PMEM_IDLE) && (pmem_read || pmem_write);

    // LATENCY=1 commits on the acceptance edge, straight from the bus.
    always_comb begin
        commit_now  = (state_q == PMEM_BUSY) && (cnt_q == '0);
        commit_wr   = wr_q;
        store_index = addr_q[LINE_BITS-1:0];
        store_wdata = wdata_q;
        if (LATENCY == 1) begin
            commit_now  = accept;
            commit_wr   = pmem_write;
            store_index = pmem_address[4 +: LINE_BITS];
            store_wdata = pmem_wdata;
        end
    end

    assign store_we = reset_n && commit_now && commit_wr;

    assign viol = (state_q == PMEM_BUSY) &&
                  (!(pmem_read || pmem_write) ||
                   ({pmem_read, pmem_write} != {rd_q, wr_q}) ||
                   (pmem_address[15:4] != addr_q) ||
                   (wr_q && (pmem_wdata != wdata_q)));

    pmem_store #(.LINE_BITS(LINE_BITS)) u_store (
        .clk     (clk),
        .write   (store_we),
        .index   (store_index),
        .datain  (store_wdata),
        .dataout (store_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= PMEM_IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            resp_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            resp_q <= 1'b0;
            if (viol) begin
                error_q <= 1'b1;
            end
            case (state_q)
                PMEM_IDLE: begin
                    if (accept) begin
                        rd_q    <= pmem_read;
                        wr_q    <= pmem_write;
                        addr_q  <= pmem_address[15:4];
                        wdata_q <= pmem_wdata;
                        if (pmem_read && pmem_write) begin
                            error_q <= 1'b1;
                        end
                        if (LATENCY == 1) begin
                            if (!pmem_write) begin
                                rdata_q <= store_rdata;
                            end
                            resp_q  <= 1'b1;
                            state_q <= PMEM_RESP;
                        end else begin
                            cnt_q   <= LAT_LOAD;
                            state_q <= PMEM_BUSY;
                        end
                    end
                end
                PMEM_BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        if (!wr_q) begin
                            rdata_q <= store_rdata;
                        end
                        resp_q  <= 1'b1;
                        state_q <= PMEM_RESP;
                    end
                end
                PMEM_RESP: state_q <= PMEM_IDLE;
                default:   state_q <= PMEM_IDLE;
            endcase
        end
    end

    assign pmem_rdata = rdata_q;
    assign pmem_resp  = resp_q;
    assign pmem_error = error_q;

endmodule
